// File: rtl/ram_ctrl_pkg.sv
// Shared RAM-control definitions: arbiter state encoding and address-width helper,
// common to the arbiter and the front-panel/UART loaders.
package ram_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Address width for a RAM of the given depth (at least one bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_addr_seq.sv
// Sequential RAM address pointer plus session byte counter; the pointer wraps
// after DEPTH-1 so a sweep never runs past the end of the RAM.
module ram_addr_seq
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic          mclk,
    input  logic          mrst_n,
    input  logic          en,
    input  logic          ptr_clr,
    input  logic          ptr_inc,
    input  logic          cnt_clr,
    input  logic          cnt_inc,
    output logic [AW-1:0] ptr,
    output logic [AW:0]   count,
    output logic          last_c
);

    assign last_c = (ptr == AW'(DEPTH - 1));

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (en) begin
            if (ptr_clr) begin
                ptr <= '0;
            end else if (ptr_inc) begin
                ptr <= last_c ? '0 : ptr + AW'(1);
            end
            if (cnt_clr) begin
                count <= '0;
            end else if (cnt_inc) begin
                count <= count + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/ram_program_arbiter.sv
// Arbitrates the shared RAM port between the SAP1 CPU (RUN) and a byte-stream loader.
// Optional pre-load zeroing sweep enabled by defining RAM_PROG_CLEAR_EN.
module ram_program_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter  int unsigned RAM_DEPTH  = 16,
    parameter  int unsigned WIDTH      = 8,
    localparam int unsigned ADDR_WIDTH = addr_width(RAM_DEPTH)
) (
    input  logic                  mclk,
    input  logic                  mrst_n,
    input  logic                  mclk_en,
    input  logic                  i_prog_mode,
    input  logic [ADDR_WIDTH-1:0] i_cpu_address,
    input  logic                  i_cpu_load_enable,
    input  logic [WIDTH-1:0]      i_cpu_load_data,
    input  logic                  i_prog_valid,
    input  logic [WIDTH-1:0]      i_prog_data,
    output logic                  o_prog_ready,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic                  o_ram_load_enable,
    output logic [WIDTH-1:0]      o_ram_load_data,
    output logic                  o_cpu_halt,
    output logic                  o_cpu_restart,
    output logic [ADDR_WIDTH:0]   o_load_count
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  ready_q;
    logic                  halt_q;
    logic                  restart_q;
    logic                  ptr_clr;
    logic                  ptr_inc;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  xfer_c;
    logic                  last_c;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   count;

    ram_addr_seq #(
        .DEPTH (RAM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_addr_seq (
        .mclk    (mclk),
        .mrst_n  (mrst_n),
        .en      (mclk_en),
        .ptr_clr (ptr_clr),
        .ptr_inc (ptr_inc),
        .cnt_clr (cnt_clr),
        .cnt_inc (cnt_inc),
        .ptr     (ptr),
        .count   (count),
        .last_c  (last_c)
    );

    // Loader handshake; the enable qualification happens in the registers.
    assign xfer_c = i_prog_valid & ready_q;

    // Next-state and RAM port mux; RUN is a zero-latency CPU pass-through.
    always_comb begin
        state_d           = state_q;
        ptr_clr           = 1'b0;
        ptr_inc           = 1'b0;
        cnt_clr           = 1'b0;
        cnt_inc           = 1'b0;
        o_ram_address     = i_cpu_address;
        o_ram_load_enable = i_cpu_load_enable;
        o_ram_load_data   = i_cpu_load_data;
        case (state_q)
            ST_RUN: begin
                if (i_prog_mode) begin
                    ptr_clr = 1'b1;
`ifdef RAM_PROG_CLEAR_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
`endif
                end
            end
`ifdef RAM_PROG_CLEAR_EN
            ST_CLEAR: begin
                o_ram_address     = ptr;
                o_ram_load_enable = 1'b1;
                o_ram_load_data   = '0;
                if (!i_prog_mode) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_inc = 1'b1;
                    if (last_c) begin
                        state_d = ST_LOAD;
                        cnt_clr = 1'b1;
                    end
                end
            end
`endif
            ST_LOAD: begin
                o_ram_address     = ptr;
                o_ram_load_enable = i_prog_valid;
                o_ram_load_data   = i_prog_data;
                if (xfer_c) begin
                    ptr_inc = 1'b1;
                    cnt_inc = 1'b1;
                end
                if (!i_prog_mode) begin
                    state_d = ST_RUN;
                end else if (xfer_c && last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_ram_address     = ptr;
                o_ram_load_enable = 1'b0;
                o_ram_load_data   = '0;
                if (!i_prog_mode) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State plus registered status; restart pulses for one enabled cycle on re-entry to RUN.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q   <= ST_RUN;
            ready_q   <= 1'b0;
            halt_q    <= 1'b0;
            restart_q <= 1'b0;
        end else if (mclk_en) begin
            state_q   <= state_d;
            ready_q   <= (state_d == ST_LOAD);
            halt_q    <= (state_d != ST_RUN);
            restart_q <= (state_d == ST_RUN) && (state_q != ST_RUN);
        end
    end

    assign o_prog_ready  = ready_q;
    assign o_cpu_halt    = halt_q;
    assign o_cpu_restart = restart_q;
    assign o_load_count  = count;

endmodule
